phy_serial_to_parallel_rx: RTL
==============================

Name: phy_serial_to_parallel_rx

Overview:
Receive-side deserializer for the PCIe PHY lane: takes the serial bitstream produced by the transmit-side parallel-to-serial stage and rebuilds bytes. It hunts for the COMMA idle symbol (0xBC), declares lock after COMMA_CNT consecutive byte-aligned commas, and then delivers non-idle bytes with a valid flag. It sits in the RX path ahead of the byte un-striping stage.

Parameters:
COMMA, 8'hBC, idle/alignment symbol
COMMA_CNT, 4, consecutive aligned commas required for lock; legal range 2..15

Ports:
clk_32f  input  1  bit clock, one serial bit per rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  1  serial bit, MSB of each byte first
data_out  output  8  last received non-comma byte
valid_out  output  1  data_out holds a byte received in the current byte period
byte_strobe  output  1  one-cycle pulse per byte boundary while active
active  output  1  lane locked

Behaviour:
- Reset: asynchronous, active-high. data_out=0, valid_out=0, byte_strobe=0, active=0, shreg=0, bitcnt=0, bc_count=0, state=SEARCH. Asserting reset mid-operation clears all state immediately; realignment is required afterwards.
- Every edge, shreg <= {shreg[6:0], data_in}. bitcnt is 3 bits and wraps 7->0. A boundary is any edge where state != SEARCH and bitcnt == 0, meaning shreg holds one complete aligned byte.
- SEARCH: checks shreg every cycle. When shreg == COMMA: bitcnt <= 1, bc_count <= 1, state <= ALIGN. Otherwise bitcnt is held at 0.
- ALIGN, at a boundary:
  - shreg == COMMA and bc_count+1 == COMMA_CNT: state <= ACTIVE, active <= 1 on the same edge.
  - shreg == COMMA otherwise: bc_count increments.
  - shreg != COMMA: state <= SEARCH, bc_count <= 0, bitcnt <= 0. Detection resumes on the following cycle.
  - No outputs change in ALIGN.
- ACTIVE, at each boundary:
  - byte_strobe <= 1 for one cycle.
  - shreg != COMMA: data_out <= shreg, valid_out <= 1.
  - shreg == COMMA: valid_out <= 0, data_out holds.
  - valid_out is held until the next boundary, so each value lasts 8 cycles.
  - The comma that completes lock is not output.
- Latency: last bit of a byte sampled at edge k. shreg is full after edge k. data_out, valid_out and byte_strobe update at edge k+1.
- ACTIVE is left only through reset; no loss-of-lock detection.
- A false comma seen in SEARCH across a byte boundary is rejected by the ALIGN check.
- The comparison always uses the registered shreg, never the combinational next value.

Optional Feature:
Macro PHY_RX_IDLE_CNT_EN.
- Defined: adds output port idle_count [15:0], reset to 0. It increments at each ACTIVE boundary where shreg == COMMA and saturates at 16'hFFFF. The lock-completing comma is not counted.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Release reset, send 4×0xBC aligned from bit 0, then 0xFF, then 0xEE -> active rises at the 4th comma's boundary+1. data_out=0xFF with valid_out=1 for 8 cycles, then 0xEE. byte_strobe pulses every 8 cycles.
- Send 3 junk bits (101) before 4×0xBC, then 0xDD -> lock at bit offset 3. data_out=0xDD, valid_out=1; no output before lock.
- Send 0xBC, 0xBC, 0x12, then 4×0xBC, then 0xCC -> active stays 0 through the 0x12 and SEARCH is re-entered. Lock occurs after the second comma run; data_out=0xCC.
- Locked, send 0xAA, 0xBC, 0x55 -> valid_out 1/0/1 across the three byte periods. data_out=0xAA is held during the comma, then becomes 0x55.
- Locked, assert reset mid-byte -> all outputs 0 immediately. After release, 0x77 without commas produces no valid_out; 4×0xBC then 0x77 -> data_out=0x77.
- With PHY_RX_IDLE_CNT_EN: lock, then 0xBC, 0xBC, 0x11, 0xBC -> idle_count=3.

Source files
------------

// File: rtl/phy_serial_to_parallel_rx.sv
// PCIe PHY lane receive deserializer.
// Hunts for the COMMA idle symbol in the serial stream. It locks after COMMA_CNT
// consecutive byte-aligned commas, then delivers the non-comma bytes with a
// valid flag.
// Optional build macro: PHY_RX_IDLE_CNT_EN adds a saturating idle_count output.
// The idle count covers the commas seen after lock.
module phy_serial_to_parallel_rx #(
    parameter logic [7:0] COMMA     = 8'hBC,
    parameter int         COMMA_CNT = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        byte_strobe,
    output logic        active
`ifdef PHY_RX_IDLE_CNT_EN
    ,
    output logic [15:0] idle_count
`endif
);

    localparam logic [3:0] LOCK_CNT = 4'(COMMA_CNT);

    typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_e;

    state_e      state_q, state_d;
    logic [7:0]  shreg_q;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [3:0]  bc_q, bc_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        strobe_q, strobe_d;
    logic        active_q, active_d;
`ifdef PHY_RX_IDLE_CNT_EN
    logic [15:0] idle_q, idle_d;
`endif

    // Decisions always look at the registered shift register, never at the
    // value being shifted in this edge.
    logic is_comma, boundary;
    assign is_comma = (shreg_q == COMMA);
    assign boundary = (state_q != SEARCH) && (bitcnt_q == 3'd0);

    // Serial shift, MSB of each byte arrives first.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) shreg_q <= 8'h00;
        else       shreg_q <= {shreg_q[6:0], data_in};
    end

    // State and output registers.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q  <= SEARCH;
            bitcnt_q <= 3'd0;
            bc_q     <= 4'd0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            active_q <= 1'b0;
`ifdef PHY_RX_IDLE_CNT_EN
            idle_q   <= 16'h0000;
`endif
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            bc_q     <= bc_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            active_q <= active_d;
`ifdef PHY_RX_IDLE_CNT_EN
            idle_q   <= idle_d;
`endif
        end
    end

    // Alignment FSM: SEARCH hunts bit by bit, ALIGN confirms on byte
    // boundaries, ACTIVE emits bytes.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q + 3'd1;
        bc_d     = bc_q;
        data_d   = data_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;
        active_d = active_q;
`ifdef PHY_RX_IDLE_CNT_EN
        idle_d   = idle_q;
`endif
        unique case (state_q)
            SEARCH: begin
                bitcnt_d = 3'd0;
                if (is_comma) begin
                    // The next byte starts on the bit being shifted in now.
                    bitcnt_d = 3'd1;
                    bc_d     = 4'd1;
                    state_d  = ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        if ((bc_q + 4'd1) == LOCK_CNT) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end else begin
                            bc_d = bc_q + 4'd1;
                        end
                    end else begin
                        // The comma was false or misaligned, so hunt again.
                        state_d  = SEARCH;
                        bc_d     = 4'd0;
                        bitcnt_d = 3'd0;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (is_comma) begin
                        valid_d = 1'b0;
`ifdef PHY_RX_IDLE_CNT_EN
                        if (idle_q != 16'hFFFF) idle_d = idle_q + 16'd1;
`endif
                    end else begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;
`ifdef PHY_RX_IDLE_CNT_EN
    assign idle_count  = idle_q;
`endif

endmodule
